// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first.
// Result flags are registered on entry to DONE and held until the next DONE.
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             opr;
    logic             xsgn;
    logic             ysgn;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] slice;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // One slice of the ripple: subtraction uses inverted y with inverted borrow-in
    always_comb begin
        sum = {1'b0, xs[DIGIT-1:0]} + {1'b0, ys[DIGIT-1:0]}
            + (DIGIT + 1)'(carry);
        slice = '0;
        slice[DIGIT-1:0] = sum[DIGIT-1:0];
        acc_next = (acc >> DIGIT) | (slice << (WIDTH - DIGIT));
        last = (cnt == LAST);
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b1;
            xs    <= '0;
            ys    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            opr   <= 1'b0;
            xsgn  <= 1'b0;
            ysgn  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs    <= x;
                        ys    <= op ? ~y : y;
                        carry <= op ^ cin;
                        opr   <= op;
                        xsgn  <= x[WIDTH-1];
                        ysgn  <= op ? ~y[WIDTH-1] : y[WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    xs    <= xs >> DIGIT;
                    ys    <= ys >> DIGIT;
                    carry <= sum[DIGIT];
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        res   <= acc_next;
                        cout  <= opr ^ sum[DIGIT];
                        ovf   <= (xsgn == ysgn) &&
                                 (acc_next[WIDTH-1] != xsgn);
                        zero  <= (acc_next == '0);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: table vectors plus start-during-RUN
// and mid-RUN reset sequences; a second instance runs with DIGIT=WIDTH.
module tb_seq_addsub;

    localparam int W = 32;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout, ovf, zero;
    logic [W-1:0]  res;
    logic          busy1, done1, cout1, ovf1, zero1;
    logic [W-1:0]  res1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(W), .DIGIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .x(x), .y(y), .cin(cin),
        .busy(busy), .done(done), .res(res),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    seq_addsub #(.WIDTH(W), .DIGIT(W)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .x(x), .y(y), .cin(cin),
        .busy(busy1), .done(done1), .res(res1),
        .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    typedef struct {
        string        nm;
        logic         op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        logic [W-1:0] prev;
        logic [W-1:0] r1;
        logic         c1;
        int           n;
        int           n1;
        bit           seen;
        bit           run_ok;
        prev = res;
        @(negedge clk);
        op = v.op; x = v.x; y = v.y; cin = v.cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = ~v.op; x = ~v.x; y = ~v.y; cin = ~v.cin;
        n = 0; n1 = 0; seen = 0; run_ok = 1; r1 = '0; c1 = 1'b0;
        while (!seen && n < 20) begin
            if (!busy || done || res !== prev) run_ok = 0;
            @(posedge clk); #1;
            n++;
            if (done1 && n1 == 0) begin
                n1 = n; r1 = res1; c1 = cout1;
            end
            if (done) seen = 1;
        end
        chk({v.nm, " latency"}, n, N);
        chk({v.nm, " run_hold"}, run_ok, 1);
        chk({v.nm, " res"}, res, v.res);
        chk({v.nm, " cout"}, cout, v.cout);
        chk({v.nm, " ovf"}, ovf, v.ovf);
        chk({v.nm, " zero"}, zero, v.zero);
        chk({v.nm, " n1_latency"}, n1, 1);
        chk({v.nm, " n1_res"}, r1, v.res);
        chk({v.nm, " n1_cout"}, c1, v.cout);
        @(posedge clk); #1;
        chk({v.nm, " done_pulse"}, {busy, done}, 2'b00);
        chk({v.nm, " res_hold"}, res, v.res);
    endtask

    initial begin
        vec_t         v;
        int           pulses;
        logic [W-1:0] r;

        vecs[0]  = '{"sub5_3",  1'b1, 32'h5, 32'h3, 1'b0,
                     32'h2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"sub3_5",  1'b1, 32'h3, 32'h5, 1'b0,
                     32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"add_maxp", 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0,
                     32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{"add_wrap", 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0,
                     32'h0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{"sub_bin", 1'b1, 32'h10, 32'h0F, 1'b1,
                     32'h0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{"sub_minn", 1'b1, 32'h80000000, 32'h1, 1'b0,
                     32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{"add_cin", 1'b0, 32'h12345678, 32'h11111111, 1'b1,
                     32'h2345678A, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"add_2neg", 1'b0, 32'h80000000, 32'h80000000, 1'b0,
                     32'h0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{"add_slice", 1'b0, 32'h000000FF, 32'h1, 1'b0,
                     32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"sub_0_0b", 1'b1, 32'h0, 32'h0, 1'b1,
                     32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"add_all1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                     32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{"sub_brw", 1'b1, 32'h100, 32'h1, 1'b0,
                     32'hFF, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst res", res, 0);
        chk("rst cout", cout, 0);
        chk("rst ovf", ovf, 0);
        chk("rst zero", zero, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // start held high through RUN with new operands
        @(negedge clk);
        op = 1'b0; x = 32'h1; y = 32'h2; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        x = 32'h100; y = 32'h200;
        pulses = 0; r = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                r = res;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("ignore_start pulses", pulses, 1);
        chk("ignore_start res", r, 32'h3);
        repeat (3) @(posedge clk);

        // reset sampled at edge 2 of RUN
        @(negedge clk);
        op = 1'b1; x = 32'h5; y = 32'h3; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst res", res, 0);
        chk("midrst zero", zero, 1);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("midrst no_done", pulses, 0);
        v = '{"after_rst", 1'b1, 32'h5, 32'h3, 1'b0,
              32'h2, 1'b0, 1'b0, 1'b0};
        run_op(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
